time_counter: RTL

Timekeeping core of the digital clock. Divides the system clock into a one-second time base, and keeps seconds, minutes and hours in binary 24-hour format. Supports per-field loading from the shared 6-bit data bus. Its `sec`, `min` and `hr` outputs feed the alarm comparator stage and the display path directly.

---
 rtl/time_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/time_counter.sv
// Timekeeping core: divides clk into a one-second base and keeps hr:min:sec (24 h, binary).
// Per-field loads from the shared data bus reset the prescaler and pre-empt any advance.
module time_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESCALE_W    = 26
) (
    input  logic       clk,
    input  logic       time_reset_n,
    input  logic       run,
    input  logic       ld_sec,
    input  logic       ld_min,
    input  logic       ld_hr,
    input  logic [5:0] input_data,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hr,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam logic [PRESCALE_W-1:0] LP_PRESCALE_TC = PRESCALE_W'(TICKS_PER_SEC - 1);

    logic [PRESCALE_W-1:0] r_prescale;
    logic [5:0]            r_sec;
    logic [5:0]            r_min;
    logic [5:0]            r_hr;
    logic                  r_sec_tick;
    logic                  r_day_wrap;
    logic                  r_load_err;

    logic w_any_ld;
    logic w_advance;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap;
    logic w_data_lt60;
    logic w_data_lt24;
    logic w_load_bad;

    assign w_any_ld    = ld_sec | ld_min | ld_hr;
    assign w_advance   = run & ~w_any_ld & (r_prescale == LP_PRESCALE_TC);
    assign w_sec_wrap  = (r_sec == 6'd59);
    assign w_min_wrap  = w_sec_wrap & (r_min == 6'd59);
    assign w_hr_wrap   = w_min_wrap & (r_hr == 6'd23);
    assign w_data_lt60 = (input_data < 6'd60);
    assign w_data_lt24 = (input_data < 6'd24);
    assign w_load_bad  = (ld_sec & ~w_data_lt60) | (ld_min & ~w_data_lt60) | (ld_hr & ~w_data_lt24);

    // Any load, even a rejected one, restarts the second so it lasts a full period.
    always_ff @(posedge clk) begin
        if (!time_reset_n) begin
            r_prescale <= '0;
        end else if (w_any_ld) begin
            r_prescale <= '0;
        end else if (run) begin
            if (r_prescale == LP_PRESCALE_TC) begin
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!time_reset_n) begin
            r_sec <= '0;
            r_min <= '0;
            r_hr  <= '0;
        end else if (w_any_ld) begin
            if (ld_sec && w_data_lt60) begin
                r_sec <= input_data;
            end
            if (ld_min && w_data_lt60) begin
                r_min <= input_data;
            end
            if (ld_hr && w_data_lt24) begin
                r_hr <= input_data;
            end
        end else if (w_advance) begin
            r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
            if (w_sec_wrap) begin
                r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
            end
            if (w_min_wrap) begin
                r_hr <= w_hr_wrap ? 6'd0 : r_hr + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!time_reset_n) begin
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= w_advance;
            r_day_wrap <= w_advance & w_hr_wrap;
            r_load_err <= w_load_bad;
        end
    end

    assign sec      = r_sec;
    assign min      = r_min;
    assign hr       = r_hr;
    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;
    assign load_err = r_load_err;

endmodule
